// File: rtl/coffee_recipe_sequencer_pkg.sv
// Shared types and default menu for the coffee recipe sequencer.
// Default tables are exposed as functions so any table size can be reset from them.
package coffee_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DISPENSE = 1'b1
  } state_e;

  localparam int ING_WATER     = 0;
  localparam int ING_COFFEE    = 1;
  localparam int ING_SUGAR     = 2;
  localparam int ING_MILK      = 3;
  localparam int ING_CHOCOLATE = 4;

  localparam int RCP_ESPRESSO  = 0;
  localparam int RCP_AMERICANO = 1;
  localparam int RCP_LATTE     = 2;
  localparam int RCP_MOCHA     = 3;

  typedef logic [7:0] dflt_t;

  function automatic dflt_t default_price(input int recipe);
    dflt_t p;
    case (recipe)
      RCP_ESPRESSO:  p = 8'd10;
      RCP_AMERICANO: p = 8'd10;
      RCP_LATTE:     p = 8'd12;
      RCP_MOCHA:     p = 8'd15;
      default:       p = 8'd0;
    endcase
    return p;
  endfunction

  // Entries outside the default menu fall back to zero.
  function automatic dflt_t default_time(input int recipe, input int ing);
    dflt_t t;
    t = 8'd0;
    case (recipe)
      RCP_ESPRESSO: begin
        case (ing)
          ING_WATER:  t = 8'd2;
          ING_COFFEE: t = 8'd2;
          default:    t = 8'd0;
        endcase
      end
      RCP_AMERICANO: begin
        case (ing)
          ING_WATER:  t = 8'd3;
          ING_COFFEE: t = 8'd1;
          ING_SUGAR:  t = 8'd1;
          default:    t = 8'd0;
        endcase
      end
      RCP_LATTE: begin
        case (ing)
          ING_WATER:  t = 8'd1;
          ING_COFFEE: t = 8'd2;
          ING_MILK:   t = 8'd2;
          default:    t = 8'd0;
        endcase
      end
      RCP_MOCHA: begin
        case (ing)
          ING_WATER:     t = 8'd1;
          ING_COFFEE:    t = 8'd1;
          ING_MILK:      t = 8'd1;
          ING_CHOCOLATE: t = 8'd2;
          default:       t = 8'd0;
        endcase
      end
      default: t = 8'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/coffee_recipe_sequencer_if.sv
// User-side bus of the sequencer: coin/button/config inputs and status/valve outputs.
interface coffee_recipe_sequencer_if #(
  parameter int NUM_INGREDIENTS = 5,
  parameter int NUM_RECIPES     = 4,
  parameter int CREDIT_W        = 5,
  parameter int TIME_W          = 4
);
  localparam int RCP_W = $clog2(NUM_RECIPES);
  localparam int SEL_W = $clog2(NUM_INGREDIENTS) + 1;
  localparam int CFG_W = (CREDIT_W > TIME_W) ? CREDIT_W : TIME_W;

  logic                       coin_100;
  logic                       coin_500;
  logic [RCP_W-1:0]           coffee_type;
  logic                       start;
  logic                       cancel;
  logic                       cfg_we;
  logic [RCP_W-1:0]           cfg_recipe;
  logic [SEL_W-1:0]           cfg_sel;
  logic [CFG_W-1:0]           cfg_data;
  logic [CREDIT_W-1:0]        credit;
  logic [CREDIT_W-1:0]        change;
  logic [NUM_INGREDIENTS-1:0] dispense;
  logic                       busy;
  logic                       finished;
  logic                       no_credit;
  logic                       coin_reject;
  logic                       cfg_err;

  modport master (
    output coin_100, coin_500, coffee_type, start, cancel,
    output cfg_we, cfg_recipe, cfg_sel, cfg_data,
    input  credit, change, dispense, busy, finished, no_credit, coin_reject, cfg_err
  );

  modport slave (
    input  coin_100, coin_500, coffee_type, start, cancel,
    input  cfg_we, cfg_recipe, cfg_sel, cfg_data,
    output credit, change, dispense, busy, finished, no_credit, coin_reject, cfg_err
  );
endinterface

// File: rtl/coffee_recipe_sequencer_tick_prescaler.sv
// Seconds prescaler: sec_tick is high on every TICKS_PER_SEC-th cycle counted from the last restart.
module tick_prescaler
  import coffee_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic sec_tick
);
  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sec_tick_q, sec_tick_d;

  // Next count and registered tick decode of that count.
  always_comb begin
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sec_tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      sec_tick_q <= (LAST == {CNT_W{1'b0}});
    end else begin
      cnt_q      <= cnt_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign sec_tick = sec_tick_q;
endmodule

// File: rtl/coffee_recipe_sequencer.sv
// Coin crediting, price check/change, and timed ingredient pouring driven from a writable recipe table.
module coffee_recipe_sequencer
  import coffee_pkg::*;
#(
  parameter int NUM_INGREDIENTS = 5,
  parameter int NUM_RECIPES     = 4,
  parameter int CREDIT_W        = 5,
  parameter int TIME_W          = 4,
  parameter int TICKS_PER_SEC   = 50_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  coffee_recipe_sequencer_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_INGREDIENTS) + 1;
  localparam int IX_W  = (NUM_INGREDIENTS > 1) ? $clog2(NUM_INGREDIENTS) : 1;
  localparam int SUM_W = CREDIT_W + 3;
  localparam logic [SUM_W-1:0] CREDIT_MAX = {3'b000, {CREDIT_W{1'b1}}};
  localparam logic [0:0] S_IDLE     = ST_IDLE;
  localparam logic [0:0] S_DISPENSE = ST_DISPENSE;

  logic [0:0]                 state_q, state_d;
  logic [CREDIT_W-1:0]        credit_q, credit_d;
  logic [CREDIT_W-1:0]        change_q, change_d;
  logic [NUM_INGREDIENTS-1:0] dispense_q, dispense_d;
  logic                       busy_q, busy_d;
  logic                       finished_q, finished_d;
  logic                       no_credit_q, no_credit_d;
  logic                       coin_reject_q, coin_reject_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       active_q, active_d;
  logic [IX_W-1:0]            cur_q, cur_d;
  logic [TIME_W-1:0]          secs_q, secs_d;
  logic [TIME_W-1:0]          lat_time_q [NUM_INGREDIENTS];
  logic [TIME_W-1:0]          lat_time_d [NUM_INGREDIENTS];
  logic [CREDIT_W-1:0]        price_q [NUM_RECIPES];
  logic [CREDIT_W-1:0]        price_d [NUM_RECIPES];
  logic [TIME_W-1:0]          time_q [NUM_RECIPES][NUM_INGREDIENTS];
  logic [TIME_W-1:0]          time_d [NUM_RECIPES][NUM_INGREDIENTS];

  logic [CREDIT_W-1:0]        row_price_s;
  logic [TIME_W-1:0]          row_time_s [NUM_INGREDIENTS];
  logic [TIME_W-1:0]          src_time_s [NUM_INGREDIENTS];
  int                         from_idx_s;
  logic                       nxt_found_s;
  logic [IX_W-1:0]            nxt_idx_s;
  logic [TIME_W-1:0]          nxt_time_s;
  logic [NUM_INGREDIENTS-1:0] nxt_onehot_s;
  logic [2:0]                 coin_add_s;
  logic [SUM_W-1:0]           coin_sum_s;
  logic                       coin_any_s;
  logic                       cfg_wr_s;
  logic                       restart_s;
  logic                       sec_tick_s;

  tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .restart  (restart_s),
    .sec_tick (sec_tick_s)
  );

  // Recipe row addressed by coffee_type, plus coin arithmetic.
  always_comb begin
    row_price_s = '0;
    for (int i = 0; i < NUM_INGREDIENTS; i++) begin
      row_time_s[i] = '0;
    end
    for (int r = 0; r < NUM_RECIPES; r++) begin
      if (int'(bus.coffee_type) == r) begin
        row_price_s = price_q[r];
        for (int i = 0; i < NUM_INGREDIENTS; i++) begin
          row_time_s[i] = time_q[r][i];
        end
      end else begin
        row_price_s = row_price_s;
      end
    end
    coin_add_s = (bus.coin_100 ? 3'd1 : 3'd0) + (bus.coin_500 ? 3'd5 : 3'd0);
    coin_sum_s = {3'b000, credit_q} + {{CREDIT_W{1'b0}}, coin_add_s};
    coin_any_s = bus.coin_100 | bus.coin_500;
  end

  // Next nonzero ingredient after from_idx: from the selected row when idle, the latched recipe when pouring.
  always_comb begin
    if (state_q == S_IDLE) begin
      from_idx_s = -1;
      for (int i = 0; i < NUM_INGREDIENTS; i++) begin
        src_time_s[i] = row_time_s[i];
      end
    end else begin
      from_idx_s = int'(cur_q);
      for (int i = 0; i < NUM_INGREDIENTS; i++) begin
        src_time_s[i] = lat_time_q[i];
      end
    end
    nxt_found_s  = 1'b0;
    nxt_idx_s    = '0;
    nxt_time_s   = '0;
    nxt_onehot_s = '0;
    for (int i = 0; i < NUM_INGREDIENTS; i++) begin
      if (!nxt_found_s && (i > from_idx_s) && (src_time_s[i] != '0)) begin
        nxt_found_s     = 1'b1;
        nxt_idx_s       = IX_W'(i);
        nxt_time_s      = src_time_s[i];
        nxt_onehot_s[i] = 1'b1;
      end else begin
        nxt_found_s = nxt_found_s;
      end
    end
  end

  // Table writes are only honoured while idle; an ongoing pour uses its latched copy.
  always_comb begin
    cfg_wr_s = bus.cfg_we & (state_q == S_IDLE);
    for (int r = 0; r < NUM_RECIPES; r++) begin
      price_d[r] = (cfg_wr_s && (int'(bus.cfg_recipe) == r) && bus.cfg_sel[SEL_W-1])
                   ? bus.cfg_data[CREDIT_W-1:0] : price_q[r];
      for (int i = 0; i < NUM_INGREDIENTS; i++) begin
        time_d[r][i] = (cfg_wr_s && (int'(bus.cfg_recipe) == r) && !bus.cfg_sel[SEL_W-1]
                        && (int'(bus.cfg_sel[SEL_W-2:0]) == i))
                       ? bus.cfg_data[TIME_W-1:0] : time_q[r][i];
      end
    end
  end

  // Main controller: crediting and purchase in IDLE, timed pouring in DISPENSE.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_d      = change_q;
    dispense_d    = dispense_q;
    active_d      = active_q;
    cur_d         = cur_q;
    secs_d        = secs_q;
    finished_d    = 1'b0;
    no_credit_d   = 1'b0;
    coin_reject_d = 1'b0;
    cfg_err_d     = 1'b0;
    restart_s     = 1'b0;
    for (int i = 0; i < NUM_INGREDIENTS; i++) begin
      lat_time_d[i] = lat_time_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          coin_reject_d = coin_any_s;
          if (credit_q >= row_price_s) begin
            state_d    = S_DISPENSE;
            change_d   = credit_q - row_price_s;
            credit_d   = '0;
            restart_s  = 1'b1;
            for (int i = 0; i < NUM_INGREDIENTS; i++) begin
              lat_time_d[i] = row_time_s[i];
            end
            active_d   = nxt_found_s;
            cur_d      = nxt_idx_s;
            secs_d     = nxt_time_s;
            dispense_d = nxt_onehot_s;
            finished_d = ~nxt_found_s;
          end else begin
            no_credit_d = 1'b1;
          end
        end else if (bus.cancel) begin
          change_d      = credit_q;
          credit_d      = '0;
          coin_reject_d = coin_any_s;
        end else if (coin_any_s) begin
          if (coin_sum_s > CREDIT_MAX) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = coin_sum_s[CREDIT_W-1:0];
            change_d = '0;
          end
        end else begin
          credit_d = credit_q;
        end
      end
      S_DISPENSE: begin
        coin_reject_d = coin_any_s;
        cfg_err_d     = bus.cfg_we;
        if (!active_q) begin
          state_d = S_IDLE;
        end else if (sec_tick_s) begin
          if (secs_q == TIME_W'(1)) begin
            // Handover restarts the prescaler so the next pour gets whole seconds.
            restart_s  = 1'b1;
            active_d   = nxt_found_s;
            cur_d      = nxt_idx_s;
            secs_d     = nxt_time_s;
            dispense_d = nxt_onehot_s;
            finished_d = ~nxt_found_s;
          end else begin
            secs_d = secs_q - TIME_W'(1);
          end
        end else begin
          secs_d = secs_q;
        end
      end
      default: begin
        state_d    = S_IDLE;
        dispense_d = '0;
        active_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == S_DISPENSE);
  end

  // State, outputs and recipe table; reset reloads the default menu.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      change_q      <= '0;
      dispense_q    <= '0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      no_credit_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      active_q      <= 1'b0;
      cur_q         <= '0;
      secs_q        <= '0;
      for (int i = 0; i < NUM_INGREDIENTS; i++) begin
        lat_time_q[i] <= '0;
      end
      for (int r = 0; r < NUM_RECIPES; r++) begin
        price_q[r] <= CREDIT_W'(default_price(r));
        for (int i = 0; i < NUM_INGREDIENTS; i++) begin
          time_q[r][i] <= TIME_W'(default_time(r, i));
        end
      end
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      change_q      <= change_d;
      dispense_q    <= dispense_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      no_credit_q   <= no_credit_d;
      coin_reject_q <= coin_reject_d;
      cfg_err_q     <= cfg_err_d;
      active_q      <= active_d;
      cur_q         <= cur_d;
      secs_q        <= secs_d;
      for (int i = 0; i < NUM_INGREDIENTS; i++) begin
        lat_time_q[i] <= lat_time_d[i];
      end
      for (int r = 0; r < NUM_RECIPES; r++) begin
        price_q[r] <= price_d[r];
        for (int i = 0; i < NUM_INGREDIENTS; i++) begin
          time_q[r][i] <= time_d[r][i];
        end
      end
    end
  end

  assign bus.credit      = credit_q;
  assign bus.change      = change_q;
  assign bus.dispense    = dispense_q;
  assign bus.busy        = busy_q;
  assign bus.finished    = finished_q;
  assign bus.no_credit   = no_credit_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.cfg_err     = cfg_err_q;
endmodule
